sha_wsched: RTL and testbench

Message-schedule generator for the SHA-256 core: accepts one 512-bit message block and streams the 64 schedule words W[0..63], one per accepted handshake, to the round datapath. The round datapath consumes each word as the W operand of that round's T1 sum. It sits directly upstream of the round adder stage.

---
 rtl/sha_pkg.sv | 18 +
 rtl/sha_wnext.sv | 16 +
 rtl/sha_wsched.sv | 88 ++++++++
 tb/tb_sha_wsched.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sha_pkg.sv
// Shared SHA-256 types and the small sigma functions used by the message
// schedule and the compression stages.
package sha_pkg;

   typedef logic [31:0] word_t;

   localparam int BLOCK_WORDS    = 16;
   localparam int ROUNDS_DEFAULT = 64;

   function automatic word_t sigma0_small(input word_t x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   function automatic word_t sigma1_small(input word_t x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
   endfunction

endpackage

// File: rtl/sha_wnext.sv
// Next schedule word from the current window taps. Kept as its own block so
// the four-input adder can later be re-shaped into a carry-save tree.
module sha_wnext
   import sha_pkg::*;
(
   input  word_t w14_i,
   input  word_t w9_i,
   input  word_t w1_i,
   input  word_t w0_i,
   output word_t next_o
);

   // Carry out of the 32-bit sum is intentionally dropped (mod 2^32).
   assign next_o = sigma1_small(w14_i) + w9_i + sigma0_small(w1_i) + w0_i;

endmodule

// File: rtl/sha_wsched.sv
// SHA-256 message schedule: loads a 512-bit block into a 16-word sliding
// window and streams W[0..ROUNDS-1] over a valid/ready handshake.
module sha_wsched
   import sha_pkg::*;
#(
   parameter int ROUNDS = ROUNDS_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         blk_valid,
   output logic         blk_ready,
   input  logic [511:0] blk_data,
   output logic         w_valid,
   input  logic         w_ready,
   output logic [31:0]  w,
   output logic [5:0]   w_round,
   output logic         w_last
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;
   localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);
   localparam logic [5:0] PRE_LAST   = 6'(ROUNDS - 2);

   logic [0:0] state_q, state_d;
   word_t      win_q [BLOCK_WORDS];
   word_t      win_d [BLOCK_WORDS];
   logic [5:0] round_q, round_d;
   logic       last_q, last_d;
   word_t      next_w;

   sha_wnext u_wnext (
      .w14_i  (win_q[14]),
      .w9_i   (win_q[9]),
      .w1_i   (win_q[1]),
      .w0_i   (win_q[0]),
      .next_o (next_w)
   );

   always_comb begin
      state_d = state_q;
      round_d = round_q;
      last_d  = last_q;
      for (int i = 0; i < BLOCK_WORDS; i++) win_d[i] = win_q[i];

      if (state_q == S_IDLE) begin
         if (blk_valid) begin
            for (int i = 0; i < BLOCK_WORDS; i++) win_d[i] = blk_data[511 - 32*i -: 32];
            round_d = 6'd0;
            last_d  = 1'b0;
            state_d = S_RUN;
         end
      end else if (w_ready) begin
         for (int i = 0; i < BLOCK_WORDS - 1; i++) win_d[i] = win_q[i+1];
         win_d[BLOCK_WORDS-1] = next_w;
         if (round_q == LAST_ROUND) begin
            state_d = S_IDLE;
            round_d = 6'd0;
            last_d  = 1'b0;
         end else begin
            round_d = round_q + 6'd1;
            last_d  = (round_q == PRE_LAST);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         round_q <= 6'd0;
         last_q  <= 1'b0;
         for (int i = 0; i < BLOCK_WORDS; i++) win_q[i] <= '0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         last_q  <= last_d;
         for (int i = 0; i < BLOCK_WORDS; i++) win_q[i] <= win_d[i];
      end
   end

   // blk_ready is gated by rst so no block can be taken during a reset cycle.
   assign blk_ready = (state_q == S_IDLE) && !rst;
   assign w_valid   = (state_q == S_RUN);
   assign w         = win_q[0];
   assign w_round   = round_q;
   assign w_last    = last_q;

endmodule

// File: tb/tb_sha_wsched.sv
// Bench for sha_wsched: random blocks and backpressure against a plain
// SHA-256 schedule model, plus a second instance built with ROUNDS=17.
module tb_sha_wsched;

   logic         clk = 1'b0;
   logic         rst;
   logic         blk_valid, blk_ready, w_valid, w_ready, w_last;
   logic [511:0] blk_data;
   logic [31:0]  w;
   logic [5:0]   w_round;

   logic         b_blk_valid, b_blk_ready, b_w_valid, b_w_ready, b_w_last;
   logic [511:0] b_blk_data;
   logic [31:0]  b_w;
   logic [5:0]   b_w_round;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int acc_cyc, done_cyc, wait_cyc;

   logic [31:0] exp_w [64];
   logic [31:0] got_w [64];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sha_wsched #(.ROUNDS(64)) dut (
      .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_ready(blk_ready),
      .blk_data(blk_data), .w_valid(w_valid), .w_ready(w_ready), .w(w),
      .w_round(w_round), .w_last(w_last)
   );

   sha_wsched #(.ROUNDS(17)) dut17 (
      .clk(clk), .rst(rst), .blk_valid(b_blk_valid), .blk_ready(b_blk_ready),
      .blk_data(b_blk_data), .w_valid(b_w_valid), .w_ready(b_w_ready), .w(b_w),
      .w_round(b_w_round), .w_last(b_w_last)
   );

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] s0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] s1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   task automatic build_model(input logic [511:0] d);
      for (int t = 0; t < 16; t++) exp_w[t] = d[511 - 32*t -: 32];
      for (int t = 16; t < 64; t++)
         exp_w[t] = s1(exp_w[t-2]) + exp_w[t-7] + s0(exp_w[t-15]) + exp_w[t-16];
   endtask

   function automatic logic [511:0] rand_blk();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   // Offers d, streams all 64 words with the given stall percentage, and
   // compares every cycle against the model. With hold set, blk_valid stays
   // high and blk_data switches to nxt while the block is running.
   task automatic run_block(input logic [511:0] d, input int stall_pct,
                            input bit hold, input logic [511:0] nxt);
      int k, budget;
      bit rdy;
      w_ready  = 1'b0;
      wait_cyc = 0;
      while (!blk_ready && wait_cyc < 200) begin
         step();
         wait_cyc++;
      end
      if (!blk_ready) begin
         check_eq("blk_ready_timeout", 64'(blk_ready), 64'd1);
         return;
      end
      blk_valid = 1'b1;
      blk_data  = d;
      acc_cyc   = cyc;
      build_model(d);
      step();
      if (hold) blk_data = nxt;
      else begin
         blk_valid = 1'b0;
         blk_data  = rand_blk();
      end
      k = 0;
      budget = 5000;
      while (k < 64 && budget > 0) begin
         rdy = ($urandom_range(99) >= stall_pct);
         w_ready = rdy;
         check_eq($sformatf("w_valid[%0d]", k), 64'(w_valid), 64'd1);
         check_eq($sformatf("w[%0d]", k), 64'(w), 64'(exp_w[k]));
         check_eq($sformatf("w_round[%0d]", k), 64'(w_round), 64'(k));
         check_eq($sformatf("w_last[%0d]", k), 64'(w_last), 64'(k == 63));
         got_w[k] = w;
         if (!hold) blk_data = rand_blk();
         step();
         budget--;
         if (rdy) k++;
      end
      if (k < 64) check_eq("word_stream_timeout", 64'(k), 64'd64);
      w_ready  = 1'b0;
      done_cyc = cyc;
      check_eq("end_w_valid", 64'(w_valid), 64'd0);
      check_eq("end_blk_ready", 64'(blk_ready), 64'd1);
   endtask

   initial begin
      logic [511:0] abc, ones, blk_a, blk_b, blk_c;
      int budget;

      rst = 1'b1;
      blk_valid = 1'b0;
      blk_data = '0;
      w_ready = 1'b0;
      b_blk_valid = 1'b0;
      b_blk_data = '0;
      b_w_ready = 1'b0;
      step();
      step();
      check_eq("rst_blk_ready", 64'(blk_ready), 64'd0);
      check_eq("rst_w_valid", 64'(w_valid), 64'd0);
      check_eq("rst_w", 64'(w), 64'd0);
      check_eq("rst_w_round", 64'(w_round), 64'd0);
      check_eq("rst_w_last", 64'(w_last), 64'd0);
      rst = 1'b0;
      #1;
      check_eq("post_rst_blk_ready", 64'(blk_ready), 64'd1);

      // "abc" reference block
      abc = {32'h61626380, 448'h0, 32'h00000018};
      run_block(abc, 0, 1'b0, '0);
      check_eq("abc_W0", 64'(got_w[0]), 64'h61626380);
      check_eq("abc_W15", 64'(got_w[15]), 64'h00000018);
      check_eq("abc_W16", 64'(got_w[16]), 64'h61626380);
      check_eq("abc_W17", 64'(got_w[17]), 64'h000F0000);
      check_eq("abc_W63", 64'(got_w[63]), 64'h12B1EDEB);
      check_eq("abc_ready_latency", 64'(done_cyc - acc_cyc), 64'd65);

      // random blocks under random backpressure
      for (int i = 0; i < 3; i++) run_block(rand_blk(), 40, 1'b0, '0);

      // all-ones block, unstalled and stalled
      ones = {512{1'b1}};
      run_block(ones, 0, 1'b0, '0);
      run_block(ones, 30, 1'b0, '0);

      // back-to-back blocks with blk_valid held high
      blk_a = rand_blk();
      blk_b = rand_blk();
      run_block(blk_a, 0, 1'b1, blk_b);
      run_block(blk_b, 0, 1'b0, '0);
      check_eq("b2b_accept_delay", 64'(wait_cyc), 64'd0);

      // reset in the middle of a block
      blk_c = rand_blk();
      build_model(blk_c);
      blk_valid = 1'b1;
      blk_data = blk_c;
      step();
      blk_valid = 1'b0;
      w_ready = 1'b1;
      for (int k = 0; k < 30; k++) begin
         check_eq($sformatf("pre_rst_w[%0d]", k), 64'(w), 64'(exp_w[k]));
         step();
      end
      check_eq("pre_rst_round", 64'(w_round), 64'd30);
      rst = 1'b1;
      w_ready = 1'b0;
      #1;
      check_eq("in_rst_blk_ready", 64'(blk_ready), 64'd0);
      step();
      rst = 1'b0;
      #1;
      check_eq("mid_rst_w_valid", 64'(w_valid), 64'd0);
      check_eq("mid_rst_w_round", 64'(w_round), 64'd0);
      check_eq("mid_rst_blk_ready", 64'(blk_ready), 64'd1);
      step();
      check_eq("mid_rst_stays_idle", 64'(w_valid), 64'd0);
      run_block(rand_blk(), 20, 1'b0, '0);

      // ROUNDS=17 instance
      blk_a = rand_blk();
      build_model(blk_a);
      check_eq("r17_blk_ready", 64'(b_blk_ready), 64'd1);
      b_blk_valid = 1'b1;
      b_blk_data = blk_a;
      step();
      b_blk_valid = 1'b0;
      b_w_ready = 1'b1;
      budget = 0;
      for (int k = 0; k < 17; k++) begin
         check_eq($sformatf("r17_w_valid[%0d]", k), 64'(b_w_valid), 64'd1);
         check_eq($sformatf("r17_w[%0d]", k), 64'(b_w), 64'(exp_w[k]));
         check_eq($sformatf("r17_w_round[%0d]", k), 64'(b_w_round), 64'(k));
         check_eq($sformatf("r17_w_last[%0d]", k), 64'(b_w_last), 64'(k == 16));
         step();
      end
      b_w_ready = 1'b0;
      check_eq("r17_end_w_valid", 64'(b_w_valid), 64'd0);
      check_eq("r17_end_blk_ready", 64'(b_blk_ready), 64'd1);
      check_eq("r17_end_round", 64'(b_w_round), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
